// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI target core: FSM state encoding,
// SCK edge selection for the four CPOL/CPHA modes and shift bit ordering.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   // Returns 1 when data is sampled on the rising SCK edge for the given mode.
   // Leading edge leaves CPOL; CPHA=0 samples on leading, CPHA=1 on trailing.
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return ~(cpol ^ cpha);
   endfunction

   // Maps a shift position (0 = first bit on the wire) to a word bit index.
   function automatic int unsigned bit_index(input int unsigned width,
                                             input logic        msb_first,
                                             input int unsigned cnt);
      return msb_first ? (width - 1 - cnt) : cnt;
   endfunction

endpackage

// File: rtl/spi_target_core_sync.sv
// N-stage synchroniser for one asynchronous pin, with a selectable reset
// value so that the synchronised signal starts at its idle level.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Next value: shift the pin into the bottom of the chain.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // Synchroniser flops; reset to the idle level so no edge is seen at release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target_core.sv
// SPI target core: synchronises the SPI pins into clk, runs the
// IDLE/LOAD/ACTIVE frame FSM, deserialises MOSI, serialises MISO and
// hands words to the fabric through read_valid/can_write pulses.
module spi_target_core
   import spi_pkg::*;
#(
   parameter int   WIDTH       = 8,
   parameter logic CPOL        = 1'b0,
   parameter logic CPHA        = 1'b0,
   parameter logic MSB_FIRST   = 1'b1,
   parameter int   SYNC_STAGES = 2,
   parameter int   CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spi_sck,
   input  logic             spi_cs_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic             spi_miso_oe,
   output logic [WIDTH-1:0] data_read,
   output logic             read_valid,
   input  logic [WIDTH-1:0] data_write,
   output logic             can_write,
   output logic             frame_active,
   output logic [CNT_W-1:0] word_count
);

   localparam int              IDX_W       = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WIDTH - 1);
   localparam logic            SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

   logic sck_s, cs_s, mosi_s;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sck (
      .clk(clk), .rst_n(rst_n), .d(spi_sck), .q(sck_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_s));
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));

   state_e             state_q, state_d;
   logic               sck_prev_q, sck_prev_d;
   logic               cs_prev_q, cs_prev_d;
   logic [WIDTH-1:0]   tx_word_q, tx_word_d;
   logic [WIDTH-1:0]   rx_shift_q, rx_shift_d;
   logic [IDX_W-1:0]   rx_cnt_q, rx_cnt_d;
   logic [IDX_W-1:0]   out_cnt_q, out_cnt_d;
   logic               word_done_q, word_done_d;
   logic               reload_q, reload_d;
   logic [WIDTH-1:0]   data_read_q, data_read_d;
   logic               read_valid_q, read_valid_d;
   logic               can_write_q, can_write_d;
   logic               frame_active_q, frame_active_d;
   logic [CNT_W-1:0]   word_count_q, word_count_d;

   logic sck_rise, sck_fall, sample_edge, shift_edge, cs_fall, cs_rise;
   logic [IDX_W-1:0] miso_idx;

   assign sck_rise    = sck_s & ~sck_prev_q;
   assign sck_fall    = ~sck_s & sck_prev_q;
   assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
   assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
   assign cs_fall     = ~cs_s & cs_prev_q;
   assign cs_rise     = cs_s & ~cs_prev_q;

   // Frame FSM next-state and datapath; a chip-select rise overrides everything.
   always_comb begin
      state_d        = state_q;
      sck_prev_d     = sck_s;
      cs_prev_d      = cs_s;
      tx_word_d      = tx_word_q;
      rx_shift_d     = rx_shift_q;
      rx_cnt_d       = rx_cnt_q;
      out_cnt_d      = out_cnt_q;
      word_done_d    = 1'b0;
      reload_d       = 1'b0;
      data_read_d    = data_read_q;
      read_valid_d   = 1'b0;
      can_write_d    = 1'b0;
      frame_active_d = frame_active_q;
      word_count_d   = word_count_q;

      unique case (state_q)
         IDLE: begin
            frame_active_d = 1'b0;
            if (cs_fall) begin
               can_write_d  = 1'b1;
               word_count_d = '0;
               state_d      = LOAD;
            end
         end
         LOAD: begin
            tx_word_d      = data_write;
            rx_cnt_d       = '0;
            out_cnt_d      = CPHA ? LAST_IDX : '0;
            frame_active_d = 1'b1;
            state_d        = ACTIVE;
         end
         ACTIVE: begin
            if (sample_edge) begin
               rx_shift_d = MSB_FIRST ? {rx_shift_q[WIDTH-2:0], mosi_s}
                                      : {mosi_s, rx_shift_q[WIDTH-1:1]};
               if (rx_cnt_q == LAST_IDX) begin
                  rx_cnt_d    = '0;
                  word_done_d = 1'b1;
               end else begin
                  rx_cnt_d = rx_cnt_q + IDX_W'(1);
               end
            end
            if (word_done_q) begin
               data_read_d  = rx_shift_q;
               read_valid_d = 1'b1;
               can_write_d  = 1'b1;
               reload_d     = 1'b1;
               if (word_count_q != '1) begin
                  word_count_d = word_count_q + CNT_W'(1);
               end
            end
            // Fabric presents the next word during the can_write cycle.
            if (reload_q) begin
               tx_word_d = data_write;
            end
            if (shift_edge) begin
               out_cnt_d = (out_cnt_q == LAST_IDX) ? '0 : out_cnt_q + IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (cs_rise) begin
         state_d        = IDLE;
         frame_active_d = 1'b0;
         word_done_d    = 1'b0;
         reload_d       = 1'b0;
         read_valid_d   = 1'b0;
         can_write_d    = 1'b0;
         data_read_d    = data_read_q;
         word_count_d   = word_count_q;
      end
   end

   // State and registered-output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         sck_prev_q     <= CPOL;
         cs_prev_q      <= 1'b1;
         tx_word_q      <= '0;
         rx_shift_q     <= '0;
         rx_cnt_q       <= '0;
         out_cnt_q      <= '0;
         word_done_q    <= 1'b0;
         reload_q       <= 1'b0;
         data_read_q    <= '0;
         read_valid_q   <= 1'b0;
         can_write_q    <= 1'b0;
         frame_active_q <= 1'b0;
         word_count_q   <= '0;
      end else begin
         state_q        <= state_d;
         sck_prev_q     <= sck_prev_d;
         cs_prev_q      <= cs_prev_d;
         tx_word_q      <= tx_word_d;
         rx_shift_q     <= rx_shift_d;
         rx_cnt_q       <= rx_cnt_d;
         out_cnt_q      <= out_cnt_d;
         word_done_q    <= word_done_d;
         reload_q       <= reload_d;
         data_read_q    <= data_read_d;
         read_valid_q   <= read_valid_d;
         can_write_q    <= can_write_d;
         frame_active_q <= frame_active_d;
         word_count_q   <= word_count_d;
      end
   end

   assign miso_idx     = IDX_W'(bit_index(WIDTH, MSB_FIRST, 32'(out_cnt_q)));
   assign spi_miso     = tx_word_q[miso_idx];
   assign spi_miso_oe  = frame_active_q;
   assign data_read    = data_read_q;
   assign read_valid   = read_valid_q;
   assign can_write    = can_write_q;
   assign frame_active = frame_active_q;
   assign word_count   = word_count_q;

endmodule
